decode_stage: RTL

//  RV32I/RV64I instruction decode stage between the fetch stage and execute.

---
 rtl/riscv_pkg.sv | 73 +++++++
 rtl/decode_imm_gen.sv | 36 +++
 rtl/decode_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared decode types, opcode/funct encodings and ALU-op helpers
package riscv_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   // M ops sit at 16+funct3, W M ops at 40+funct3, branches at 48+funct3
   typedef enum logic [5:0] {
      ALU_ADD  = 6'd0,  ALU_SUB   = 6'd1,  ALU_SLL    = 6'd2,  ALU_SLT   = 6'd3,
      ALU_SLTU = 6'd4,  ALU_XOR   = 6'd5,  ALU_SRL    = 6'd6,  ALU_SRA   = 6'd7,
      ALU_OR   = 6'd8,  ALU_AND   = 6'd9,  ALU_LUI    = 6'd10, ALU_AUIPC = 6'd11,
      ALU_MUL  = 6'd16, ALU_MULH  = 6'd17, ALU_MULHSU = 6'd18, ALU_MULHU = 6'd19,
      ALU_DIV  = 6'd20, ALU_DIVU  = 6'd21, ALU_REM    = 6'd22, ALU_REMU  = 6'd23,
      ALU_ADDW = 6'd32, ALU_SUBW  = 6'd33, ALU_SLLW   = 6'd34, ALU_SRLW  = 6'd35,
      ALU_SRAW = 6'd36, ALU_MULW  = 6'd40, ALU_DIVW   = 6'd44, ALU_DIVUW = 6'd45,
      ALU_REMW = 6'd46, ALU_REMUW = 6'd47, ALU_BEQ    = 6'd48, ALU_BNE   = 6'd49,
      ALU_BLT  = 6'd52, ALU_BGE   = 6'd53, ALU_BLTU   = 6'd54, ALU_BGEU  = 6'd55
   } alu_op_t;

   typedef enum logic [2:0] {
      EU_ALU, EU_LOAD, EU_STORE, EU_BRANCH, EU_JUMP, EU_MUL, EU_DIV, EU_ILLEGAL
   } exec_unit_t;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_OUT, ST_SKID} state_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       rd_we;
      alu_op_t    alu_op;
      exec_unit_t unit;
   } decode_bundle_t;

   function automatic alu_op_t alu_base(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_op_t alu_w(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_SLL:  return ALU_SLLW;
         F3_SR:   return alt ? ALU_SRAW : ALU_SRLW;
         default: return alt ? ALU_SUBW : ALU_ADDW;
      endcase
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: instruction word -> sign-extended immediate and its format
module decode_imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt
);

   logic [31:0] imm32;

   // pick the format from the opcode and assemble the 32-bit immediate
   always_comb begin
      case (instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: fmt = FMT_I;
         OPC_STORE:                                     fmt = FMT_S;
         OPC_BRANCH:                                    fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                            fmt = FMT_U;
         OPC_JAL:                                       fmt = FMT_J;
         default:                                       fmt = FMT_R;
      endcase
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I decode with a registered, skid-buffered output handshake
// Optional feature: define DECODE_MEXT_EN to decode the M extension into MUL/DIV units
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SKID_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            fetch_instr_valid_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   input  logic [31:0]     fetch_instr_i,
   output logic            fetch_instr_ready_o,
   input  logic            flush_i,
   output logic [4:0]      rs1_raddr_o,
   output logic [4:0]      rs2_raddr_o,
   input  logic [XLEN-1:0] rs1_rdata_i,
   input  logic [XLEN-1:0] rs2_rdata_i,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_rd_we_o,
   output alu_op_t         ex_alu_op_o,
   output exec_unit_t      ex_unit_o,
   output logic [XLEN-1:0] ex_target_o
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      decode_bundle_t  ctl;
   } entry_t;

   state_t          state_q, state_d;
   entry_t          out_q, skid_q, dec;
   logic [XLEN-1:0] imm;
   imm_fmt_t        fmt;
   exec_unit_t      unit;
   alu_op_t         alu;
   logic            accept, sh_ok, sra_ok;
   logic [6:0]      op, f7;
   logic [2:0]      f3;

   assign op          = fetch_instr_i[6:0];
   assign f3          = fetch_instr_i[14:12];
   assign f7          = fetch_instr_i[31:25];
   assign rs1_raddr_o = fetch_instr_i[19:15];
   assign rs2_raddr_o = fetch_instr_i[24:20];
   // RV64 shift amounts borrow f7[0]; on RV32 that bit must stay clear
   assign sh_ok  = f7[6:1] == 6'b000000 && (XLEN == 64 || !f7[0]);
   assign sra_ok = f7[6:1] == 6'b010000 && (XLEN == 64 || !f7[0]);

   decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (fetch_instr_i),
      .imm   (imm),
      .fmt   (fmt)
   );

   // classify the instruction into an execution unit and ALU operation
   always_comb begin
      unit = EU_ILLEGAL;
      alu  = ALU_ADD;
      case (op)
         OPC_LUI:    begin unit = EU_ALU; alu = ALU_LUI; end
         OPC_AUIPC:  begin unit = EU_ALU; alu = ALU_AUIPC; end
         OPC_JAL:    unit = EU_JUMP;
         OPC_JALR:   unit = (f3 == F3_ADD) ? EU_JUMP : EU_ILLEGAL;
         OPC_BRANCH: if (f3[2:1] != 2'b01) begin unit = EU_BRANCH; alu = alu_op_t'({3'b110, f3}); end
         OPC_LOAD:   unit = (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) ? EU_ILLEGAL : EU_LOAD;
         OPC_STORE:  unit = (f3[2] || (XLEN == 32 && f3 == 3'b011)) ? EU_ILLEGAL : EU_STORE;
         OPC_OP_IMM: if (f3 == F3_SLL ? sh_ok : f3 == F3_SR ? (sh_ok || sra_ok) : 1'b1) begin
            unit = EU_ALU;
            alu  = alu_base(f3, f3 == F3_SR && sra_ok);
         end
         OPC_OP: if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
            unit = EU_ALU;
            alu  = alu_base(f3, f7 == F7_ALT);
         end
`ifdef DECODE_MEXT_EN
         else if (f7 == F7_MULDIV) begin
            unit = f3[2] ? EU_DIV : EU_MUL;
            alu  = alu_op_t'({3'b010, f3});
         end
`endif
         OPC_OP_IMM_32: if (XLEN == 64 && (f3 == F3_ADD || (f3 == F3_SLL && f7 == F7_BASE) ||
                                           (f3 == F3_SR && (f7 == F7_BASE || f7 == F7_ALT)))) begin
            unit = EU_ALU;
            alu  = alu_w(f3, f3 == F3_SR && f7 == F7_ALT);
         end
         OPC_OP_32: if (XLEN == 64 && ((f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_SLL || f3 == F3_SR)) ||
                                       (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)))) begin
            unit = EU_ALU;
            alu  = alu_w(f3, f7 == F7_ALT);
         end
`ifdef DECODE_MEXT_EN
         else if (XLEN == 64 && f7 == F7_MULDIV && (f3 == F3_ADD || f3[2])) begin
            unit = f3[2] ? EU_DIV : EU_MUL;
            alu  = alu_op_t'({3'b101, f3});
         end
`endif
         default: ;
      endcase
   end

   assign dec = '{
      pc:     fetch_pc_i,
      rs1:    rs1_rdata_i,
      rs2:    rs2_rdata_i,
      imm:    imm,
      target: (unit == EU_BRANCH || fmt == FMT_J) ? fetch_pc_i + imm : '0,
      ctl:    '{rd:     fetch_instr_i[11:7],
                rd_we:  !(unit inside {EU_STORE, EU_BRANCH, EU_ILLEGAL}) && fetch_instr_i[11:7] != 5'd0,
                alu_op: alu,
                unit:   unit}
   };

   // state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= ST_EMPTY;
      else         state_q <= state_d;
   end

   // next state; flush overrides every transition
   always_comb begin
      case (state_q)
         ST_EMPTY: state_d = accept ? ST_OUT : ST_EMPTY;
         ST_OUT:   state_d = (SKID_DEPTH == 2 && accept && !ex_ready_i) ? ST_SKID :
                             (ex_ready_i && !accept) ? ST_EMPTY : ST_OUT;
         ST_SKID:  state_d = ex_ready_i ? ST_OUT : ST_SKID;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush_i) state_d = ST_EMPTY;
   end

   // handshake outputs; with a skid entry ready depends on state alone
   always_comb begin
      ex_valid_o          = state_q != ST_EMPTY;
      fetch_instr_ready_o = rst_ni && (SKID_DEPTH == 2 ? state_q != ST_SKID : (state_q == ST_EMPTY || ex_ready_i));
      accept              = fetch_instr_valid_i && fetch_instr_ready_o;
   end

   // output and skid buffers; nothing is captured during a flush
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_q  <= '0;
         skid_q <= '0;
      end else if (!flush_i) begin
         if (state_q == ST_SKID && ex_ready_i) out_q <= skid_q;
         else if (accept && (state_q == ST_EMPTY || ex_ready_i)) out_q <= dec;
         if (state_q == ST_OUT && accept && !ex_ready_i) skid_q <= dec;
      end
   end

   assign ex_pc_o       = out_q.pc;
   assign ex_rs1_data_o = out_q.rs1;
   assign ex_rs2_data_o = out_q.rs2;
   assign ex_imm_o      = out_q.imm;
   assign ex_target_o   = out_q.target;
   assign ex_rd_o       = out_q.ctl.rd;
   assign ex_rd_we_o    = out_q.ctl.rd_we;
   assign ex_alu_op_o   = out_q.ctl.alu_op;
   assign ex_unit_o     = out_q.ctl.unit;

endmodule
